// File: rtl/sar_search.sv
`default_nettype none
// ============================================================================
// Module      : sar_search
// Description : Successive-approximation search for an unknown value A. The
//               trial value B_O is driven to an external magnitude comparator,
//               and its L_T/G_T/E_Q result steers the search one bit per
//               SET/CMP pair, MSB first. The search ends early on equality.
//               A comparator result that is not one-hot parks the block in
//               FAULT until the next START.
// Revision    : 1.0 - initial release
// ============================================================================
module sar_search #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             START,
  input  logic             L_T,
  input  logic             G_T,
  input  logic             E_Q,
  output logic [WIDTH-1:0] B_O,
  output logic             G_O,
  output logic             E_O,
  output logic             L_O,
  output logic [WIDTH-1:0] VAL,
  output logic             BUSY,
  output logic             DONE,
  output logic             EXACT,
  output logic             ERR
);

  // Bit-pointer width; at least one bit so WIDTH=1 still elaborates.
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // First trial value: only the MSB set.
  localparam logic [WIDTH-1:0] C_TRIAL0 = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SET   = 3'd1,
    S_CMP   = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    ptr_q,   ptr_d;
  logic [WIDTH-1:0] r_q,     r_d;
  logic [WIDTH-1:0] bo_q,    bo_d;
  logic [WIDTH-1:0] val_q,   val_d;
  logic             exact_q, exact_d;

  logic [WIDTH-1:0] bit_cur;
  logic [WIDTH-1:0] bit_next;
  logic [WIDTH-1:0] r_upd;
  logic             flags_ok;

  // Masks for the bit under test and the one below it, plus the partial
  // result after folding in the current comparator decision.
  always_comb begin
    bit_cur  = WIDTH'(1) << ptr_q;
    bit_next = '0;
    if (ptr_q != '0) begin
      bit_next = WIDTH'(1) << (ptr_q - IW'(1));
    end
    // A > trial keeps the trial bit; A < trial drops it.
    r_upd = G_T ? (r_q | bit_cur) : (r_q & ~bit_cur);
  end

  // A sane comparator asserts exactly one of its three result flags.
  always_comb begin
    flags_ok = 1'b0;
    unique case ({L_T, G_T, E_Q})
      3'b100, 3'b010, 3'b001: flags_ok = 1'b1;
      default:                flags_ok = 1'b0;
    endcase
  end

  // Next-state and datapath update for the search sequencer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    r_d     = r_q;
    bo_d    = bo_q;
    val_d   = val_q;
    exact_d = exact_q;

    unique case (state_q)
      S_IDLE, S_FAULT: begin
        if (START) begin
          r_d     = '0;
          ptr_d   = IW'(WIDTH - 1);
          bo_d    = C_TRIAL0;
          val_d   = '0;
          exact_d = 1'b0;
          state_d = S_SET;
        end
      end

      // One dead cycle so the comparator sees a stable B_O.
      S_SET: begin
        state_d = S_CMP;
      end

      S_CMP: begin
        if (!flags_ok) begin
          state_d = S_FAULT;
        end else if (E_Q) begin
          val_d   = bo_q;
          exact_d = 1'b1;
          state_d = S_DONE;
        end else begin
          r_d = r_upd;
          if (ptr_q != '0) begin
            ptr_d   = ptr_q - IW'(1);
            bo_d    = r_upd | bit_next;
            state_d = S_SET;
          end else begin
            val_d   = r_upd;
            exact_d = 1'b0;
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      r_q     <= '0;
      bo_q    <= '0;
      val_q   <= '0;
      exact_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      r_q     <= r_d;
      bo_q    <= bo_d;
      val_q   <= val_d;
      exact_q <= exact_d;
    end
  end

  assign B_O   = bo_q;
  assign VAL   = val_q;
  assign EXACT = exact_q;
  assign BUSY  = (state_q == S_SET) || (state_q == S_CMP);
  assign DONE  = (state_q == S_DONE);
  assign ERR   = (state_q == S_FAULT);

  // Comparator cascade inputs tied so it behaves as a standalone compare.
  assign G_O = 1'b0;
  assign E_O = 1'b1;
  assign L_O = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_sar_search.sv
`default_nettype none
// ============================================================================
// Module      : tb_sar_search
// Description : Self-checking bench for sar_search: table of all A values,
//               directed fault/reset sequences, START-held sweep, and a
//               randomized run against a behavioural search model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sar_search;

  localparam int W = 3;

  logic         clk;
  logic         rst;
  logic         start;
  logic         l_t, g_t, e_q;
  logic [W-1:0] b_o, val;
  logic         g_o, e_o, l_o, busy, done, exact, err;

  logic [W-1:0] a_val;
  logic         bad_en;
  logic [2:0]   bad_pat;

  int n_vec;
  int n_bad;
  int cur_a;

  sar_search #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .START (start),
    .L_T   (l_t),
    .G_T   (g_t),
    .E_Q   (e_q),
    .B_O   (b_o),
    .G_O   (g_o),
    .E_O   (e_o),
    .L_O   (l_o),
    .VAL   (val),
    .BUSY  (busy),
    .DONE  (done),
    .EXACT (exact),
    .ERR   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External comparator against the hidden value A, with fault override.
  always_comb begin
    if (bad_en) {l_t, g_t, e_q} = bad_pat;
    else        {l_t, g_t, e_q} = {a_val < b_o, a_val > b_o, a_val == b_o};
  end

  typedef struct {
    int             a;
    int             n;
    logic [W*W-1:0] tr;
    int             val;
    bit             exact;
  } vec_t;

  vec_t tab[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (A=%0d): got %0d, expected %0d", name, cur_a, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " B_O"},   32'(b_o),   32'd0);
    chk({tag, " VAL"},   32'(val),   32'd0);
    chk({tag, " BUSY"},  32'(busy),  32'd0);
    chk({tag, " DONE"},  32'(done),  32'd0);
    chk({tag, " EXACT"}, 32'(exact), 32'd0);
    chk({tag, " ERR"},   32'(err),   32'd0);
    chk({tag, " G_O"},   32'(g_o),   32'd0);
    chk({tag, " E_O"},   32'(e_o),   32'd1);
    chk({tag, " L_O"},   32'(l_o),   32'd0);
  endtask

  // Reference: trial at bit i is A's bits above i with bit i set; the
  // search stops once a trial equals A, or after the last bit.
  function automatic void ref_search(input int a, output int n, output logic [W*W-1:0] tr,
                                     output bit ex);
    int t;
    n  = 0;
    tr = '0;
    ex = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      t = ((a >> (i + 1)) << (i + 1)) | (1 << i);
      tr[n*W +: W] = W'(t);
      n++;
      if (t == a) begin
        ex = 1'b1;
        break;
      end
    end
  endfunction

  // Entered at a negedge with the DUT in IDLE or FAULT; returns at the
  // negedge after DONE (IDLE) or at the first FAULT negedge.
  task automatic run_search(input int a, input int n, input logic [W*W-1:0] tr,
                            input int exp_val, input bit exp_exact, input int fault_at,
                            input logic [2:0] pat, input bit noise, input bit hold);
    int last;
    cur_a   = a;
    a_val   = W'(a);
    bad_pat = pat;
    start   = 1'b1;
    last    = (fault_at >= 0) ? 2 * fault_at + 1 : 2 * n - 1;
    @(posedge clk);
    for (int j = 0; j <= last; j++) begin
      @(negedge clk);
      start  = hold ? 1'b1 : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
      bad_en = (fault_at >= 0) && (j == 2 * fault_at + 1);
      chk("busy BUSY", 32'(busy), 32'd1);
      chk("busy DONE", 32'(done), 32'd0);
      chk("busy ERR",  32'(err),  32'd0);
      chk("trial B_O", 32'(b_o),  32'(tr[(j/2)*W +: W]));
      if (j == 0) begin
        chk("search VAL cleared", 32'(val), 32'd0);
        chk("cascade E_O", 32'(e_o), 32'd1);
      end
    end
    @(negedge clk);
    bad_en = 1'b0;
    if (fault_at >= 0) begin
      start = 1'b0;
      chk("fault ERR",   32'(err),   32'd1);
      chk("fault BUSY",  32'(busy),  32'd0);
      chk("fault DONE",  32'(done),  32'd0);
      chk("fault VAL",   32'(val),   32'd0);
      chk("fault EXACT", 32'(exact), 32'd0);
    end else begin
      start = hold;
      chk("done DONE",  32'(done),  32'd1);
      chk("done BUSY",  32'(busy),  32'd0);
      chk("done VAL",   32'(val),   32'(exp_val));
      chk("done EXACT", 32'(exact), 32'(exp_exact));
      chk("done ERR",   32'(err),   32'd0);
      @(negedge clk);
      start = hold;
      chk("idle DONE pulse", 32'(done),  32'd0);
      chk("idle BUSY",       32'(busy),  32'd0);
      chk("idle VAL held",   32'(val),   32'(exp_val));
      chk("idle EXACT held", 32'(exact), 32'(exp_exact));
    end
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int             n, f, pi;
    logic [W*W-1:0] tr;
    bit             ex;
    logic [2:0]     p;

    n_vec = 0; n_bad = 0; cur_a = 0;
    rst = 1'b1; start = 1'b0; a_val = '0; bad_en = 1'b0; bad_pat = 3'b000;

    tab[0] = '{0, 3, {3'd1, 3'd2, 3'd4}, 0, 1'b0};
    tab[1] = '{1, 3, {3'd1, 3'd2, 3'd4}, 1, 1'b1};
    tab[2] = '{2, 2, {3'd0, 3'd2, 3'd4}, 2, 1'b1};
    tab[3] = '{3, 3, {3'd3, 3'd2, 3'd4}, 3, 1'b1};
    tab[4] = '{4, 1, {3'd0, 3'd0, 3'd4}, 4, 1'b1};
    tab[5] = '{5, 3, {3'd5, 3'd6, 3'd4}, 5, 1'b1};
    tab[6] = '{6, 2, {3'd0, 3'd6, 3'd4}, 6, 1'b1};
    tab[7] = '{7, 3, {3'd7, 3'd6, 3'd4}, 7, 1'b1};

    // Reset with START asserted: reset must win.
    start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk_reset_state("idle after reset");

    // All eight values from the hand-derived table.
    for (int i = 0; i < 8; i++) begin
      run_search(tab[i].a, tab[i].n, tab[i].tr, tab[i].val, tab[i].exact, -1, 3'b000, 1'b0, 1'b0);
    end

    // Bad flags on the first compare, then recovery via START from FAULT.
    run_search(5, 3, tab[5].tr, 0, 1'b0, 0, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    chk("fault ERR held", 32'(err), 32'd1);
    chk("fault B_O held", 32'(b_o), 32'd4);
    run_search(4, 1, tab[4].tr, 4, 1'b1, -1, 3'b000, 1'b0, 1'b0);

    // Reset at the third edge of a search for A=7, START pulsing throughout.
    cur_a = 7; a_val = 3'd7; start = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      start = 1'b1;
      chk("pre-reset BUSY", 32'(busy), 32'd1);
      chk("pre-reset B_O", 32'(b_o), 32'd4);
    end
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    chk_reset_state("mid-search reset");
    @(negedge clk);
    chk("reset over START BUSY", 32'(busy), 32'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);

    // Reset clears a held result.
    run_search(5, 3, tab[5].tr, 5, 1'b1, -1, 3'b000, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("post-done reset VAL", 32'(val), 32'd0);
    chk("post-done reset EXACT", 32'(exact), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back sweep with START held high.
    for (int a = 0; a < 8; a++) begin
      ref_search(a, n, tr, ex);
      run_search(a, n, tr, a, ex, -1, 3'b000, 1'b0, a != 7);
    end
    start = 1'b0;
    @(negedge clk);

    // Randomized searches against the reference model.
    for (int it = 0; it < 40; it++) begin
      int a;
      a = int'($urandom_range(0, 7));
      ref_search(a, n, tr, ex);
      f = -1;
      p = 3'b000;
      if ($urandom_range(0, 4) == 0) begin
        f  = int'($urandom_range(0, n - 1));
        pi = int'($urandom_range(0, 4));
        case (pi)
          0: p = 3'b000;
          1: p = 3'b011;
          2: p = 3'b101;
          3: p = 3'b110;
          default: p = 3'b111;
        endcase
      end
      run_search(a, n, tr, a, ex, f, p, 1'($urandom_range(0, 1)), 1'b0);
      repeat (int'($urandom_range(0, 2))) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sar_search.md
SAR_SEARCH -- requirements
Module: sar_search

Interface
REQ-001 Parameter WIDTH, default 3: width of the searched value and of the comparator operand.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 START  input  1  request a new search; accepted only in IDLE or FAULT.
REQ-006 L_T  input  1  external comparator result: unknown operand A < B_O.
REQ-007 G_T  input  1  external comparator result: A > B_O.
REQ-008 E_Q  input  1  external comparator result: A == B_O.
REQ-009 B_O  output  WIDTH  trial value driven to the comparator B operand, registered.
REQ-010 G_O  output  1  cascade input to the comparator, constant 0.
REQ-011 E_O  output  1  cascade input to the comparator, constant 1.
REQ-012 L_O  output  1  cascade input to the comparator, constant 0.
REQ-013 VAL  output  WIDTH  search result, registered, held until the next accepted START or rst.
REQ-014 BUSY  output  1  high in SET and CMP states.
REQ-015 DONE  output  1  one-cycle pulse when VAL is valid.
REQ-016 EXACT  output  1  set with DONE if the search ended on E_Q=1; held with VAL.
REQ-017 ERR  output  1  high while in FAULT.

Function
REQ-018 States: IDLE, SET, CMP, DONE, FAULT.
REQ-019 Internal bit pointer i runs from WIDTH-1 down to 0; partial result R starts at 0.
REQ-020 IDLE/FAULT with START=1: R<=0, i<=WIDTH-1, B_O<=1<<(WIDTH-1), VAL<=0, EXACT<=0, go to SET; in FAULT, ERR clears on that edge.
REQ-021 SET lasts exactly one cycle (comparator settle) and always goes to CMP.
REQ-022 CMP samples L_T/G_T/E_Q at the end of its single cycle.
REQ-023 Flags sampled in CMP SHALL be one-hot; any other pattern (000, 011, 111, ...) goes to FAULT, ERR=1, with no DONE pulse and VAL unchanged.
REQ-024 CMP with E_Q=1: VAL<=B_O, EXACT<=1, go to DONE (early termination).
REQ-025 CMP with G_T=1: bit i of R kept at 1; CMP with L_T=1: bit i of R cleared.
REQ-026 CMP at i>0 without E_Q: i<=i-1, B_O<=R_updated | (1<<(i-1)), go to SET.
REQ-027 CMP at i=0 without E_Q: VAL<=R_updated, EXACT<=0, go to DONE.
REQ-028 DONE lasts one cycle with DONE=1, then IDLE unconditionally; START during DONE is ignored.
REQ-029 START during SET or CMP is ignored; B_O holds its value outside CMP->SET transitions.
REQ-030 Latency: START accepted at edge k; first sample at edge k+2; worst case DONE=1 in the cycle after edge k+2*WIDTH.
REQ-031 For WIDTH=3 and a consistent comparator, VAL SHALL equal A for all 8 values of A.

Reset
REQ-032 rst=1 at any edge, including mid-search, forces IDLE, B_O=0, VAL=0, BUSY=0, DONE=0, EXACT=0, ERR=0; rst overrides START.
REQ-033 G_O=0, E_O=1, L_O=0 at all times, including during reset.

Verification
REQ-034 A=4, START at edge k -> B_O=4, E_Q at first sample, DONE=1 after edge k+2, VAL=4, EXACT=1.
REQ-035 A=5 -> B_O sequence 4,6,5; flags G,L,E; DONE after edge k+6, VAL=5, EXACT=1.
REQ-036 A=0 -> B_O sequence 4,2,1, all L_T; DONE after edge k+6, VAL=0, EXACT=0.
REQ-037 Flags forced to 000 in the first CMP -> FAULT, ERR=1, BUSY=0, no DONE; next START clears ERR and restarts with B_O=4.
REQ-038 rst at edge k+3 of a search for A=7 -> all outputs at reset values after that edge; START pulses during SET/CMP ignored.
REQ-039 Sweep A=0..7 with START held high -> each search returns VAL=A with one DONE pulse, and the next search starts from IDLE.
